// File: rtl/addsub_seq_if.sv
// addsub_seq_if: request/response bundle between a requester and addsub_seq.
//   master : drives start, op_sub, op_a, op_b; observes ready, done, result, flags
//   slave  : the controller side (addsub_seq)
// Signals:
//   start   request, taken only while ready=1
//   op_sub  0 = A+B, 1 = A-B
//   op_a    operand A (WIDTH bits)
//   op_b    operand B (WIDTH bits)
//   ready   controller idle and able to accept
//   done    one-cycle completion pulse
//   result  sum/difference modulo 2^WIDTH
//   cout    carry out of MSB (no-borrow for subtraction)
//   ovf     two's-complement overflow
//   zero    result == 0
interface addsub_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op_sub, op_a, op_b,
    input  ready, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op_sub, op_a, op_b,
    output ready, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle N-nibble adder/subtractor. A single 4-bit
// carry-lookahead adder is walked over the operand nibbles LSB first, with the
// carry held in a register between cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active high
//   bus  addsub_seq_if.slave (start/op_sub/op_a/op_b in; ready/done/result/
//        cout/ovf/zero out)

// 4-bit carry-lookahead adder. No carry-out port: the caller rebuilds it
// from the MSB operands and sum bit.
module adder (
  output logic [3:0] s,
  output logic       ovf,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    ovf  = c[3] ^ c[4];
  end
endmodule

module addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus
);
  localparam int WIDTH = 4 * NIBBLES;
  // One extra bit so k can reach NIBBLES without wrapping.
  localparam int KW = $clog2(NIBBLES) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_ovf;
  logic       c4;

  // Nibble k of the latched operands; B is inverted for subtraction and the
  // +1 of the two's complement enters as the first cin.
  always_comb begin
    add_a = 4'h0;
    add_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        add_a = a_q[4*i +: 4];
        add_b = b_q[4*i +: 4];
      end
    end
    add_b   = add_b ^ {4{sub_q}};
    add_cin = (k_q == '0) ? sub_q : carry_q;
  end

  adder u_adder (
    .s   (add_s),
    .ovf (add_ovf),
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin)
  );

  // Carry out of bit 3 rebuilt from a3, b3 and s3 (s3 = a3^b3^c3).
  assign c4 = (add_a[3] & add_b[3]) | ((add_a[3] | add_b[3]) & ~add_s[3]);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          sub_d    = bus.op_sub;
          k_d      = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) result_d[4*i +: 4] = add_s;
        end
        carry_d = c4;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          cout_d  = c4;
          ovf_d   = add_ovf;
          // Registered on entry to DONE so it is not asserted out of reset.
          zero_d  = (result_d == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Operand latches carry no reset: they are only read after a fresh load.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Testbench for addsub_seq: three instances (NIBBLES = 1, 4, 8) sharing clock
// and reset, directed scenarios plus random vectors against an arithmetic model.
module tb_addsub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_seq_if #(.NIBBLES(1)) if1 ();
  addsub_seq_if #(.NIBBLES(4)) if4 ();
  addsub_seq_if #(.NIBBLES(8)) if8 ();

  addsub_seq #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  addsub_seq #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  addsub_seq #(.NIBBLES(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, output logic [31:0] res,
                                output logic co, output logic ov, output logic zr);
    longint m, half, ua, ub, sa, sb, ur, sr;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) % m;
    ub   = longint'(b) % m;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      co = (ur >= m);
    end
    res = 32'(((ur % m) + m) % m);
    ov  = (sr >= half) || (sr < -half);
    zr  = (res == 32'h0);
  endfunction

  task automatic set_in(input int which, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic sub);
    case (which)
      1: begin if1.start = st; if1.op_a = a[3:0];  if1.op_b = b[3:0];  if1.op_sub = sub; end
      4: begin if4.start = st; if4.op_a = a[15:0]; if4.op_b = b[15:0]; if4.op_sub = sub; end
      default: begin if8.start = st; if8.op_a = a; if8.op_b = b; if8.op_sub = sub; end
    endcase
  endtask

  task automatic get_out(input int which, output logic rdy, output logic dn,
                         output logic [31:0] res, output logic co, output logic ov,
                         output logic zr);
    case (which)
      1: begin rdy = if1.ready; dn = if1.done; res = 32'(if1.result); co = if1.cout; ov = if1.ovf; zr = if1.zero; end
      4: begin rdy = if4.ready; dn = if4.done; res = 32'(if4.result); co = if4.cout; ov = if4.ovf; zr = if4.zero; end
      default: begin rdy = if8.ready; dn = if8.done; res = if8.result; co = if8.cout; ov = if8.ovf; zr = if8.zero; end
    endcase
  endtask

  // Waits for ready, issues one request, scrambles the inputs after the
  // accept edge, and returns the outputs seen in the done cycle.
  // lat = cycle index of done (1 = cycle right after the accept edge), -1 if none.
  task automatic run_op(input int which, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, output logic [31:0] res, output logic co,
                        output logic ov, output logic zr, output int lat);
    logic rdy, dn;
    int g;
    g = 0;
    @(negedge clk);
    get_out(which, rdy, dn, res, co, ov, zr);
    while (!rdy && g < 30) begin
      @(negedge clk);
      get_out(which, rdy, dn, res, co, ov, zr);
      g++;
    end
    set_in(which, 1'b1, a, b, sub);
    @(posedge clk); #1;
    set_in(which, 1'b0, ~a, ~b, ~sub);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      get_out(which, rdy, dn, res, co, ov, zr);
      if (dn) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic rdy, dn, co, ov, zr;
    logic [31:0] res;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    get_out(4, rdy, dn, res, co, ov, zr);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", rdy); end
    n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", dn); end
    n_checks++; if ({res, co, ov, zr} !== 35'h0) begin n_fail++; $display("FAIL reset outputs: got res=%h c=%b o=%b z=%b expected all 0", res, co, ov, zr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic co, ov, zr;
    logic [31:0] res;
    int lat;
    run_op(4, 32'h7FFF, 32'h0001, 1'b0, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'h8000, 3'b010}) begin n_fail++; $display("FAIL add_ovf: got res=%h c=%b o=%b z=%b expected res=8000 c=0 o=1 z=0", res, co, ov, zr); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL add_ovf latency: got %0d expected 5", lat); end
    run_op(4, 32'hFFFF, 32'h0001, 1'b0, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'h0000, 3'b101}) begin n_fail++; $display("FAIL add_wrap: got res=%h c=%b o=%b z=%b expected res=0000 c=1 o=0 z=1", res, co, ov, zr); end
    run_op(4, 32'h0000, 32'h0001, 1'b1, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'hFFFF, 3'b000}) begin n_fail++; $display("FAIL sub_borrow: got res=%h c=%b o=%b z=%b expected res=ffff c=0 o=0 z=0", res, co, ov, zr); end
    run_op(4, 32'h8000, 32'h0001, 1'b1, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'h7FFF, 3'b110}) begin n_fail++; $display("FAIL sub_ovf: got res=%h c=%b o=%b z=%b expected res=7fff c=1 o=1 z=0", res, co, ov, zr); end
  endtask

  task automatic test_busy_hold;
    logic rdy, dn, co, ov, zr;
    logic [31:0] res;
    int g;
    @(negedge clk);
    get_out(4, rdy, dn, res, co, ov, zr);
    g = 0;
    while (!rdy && g < 30) begin @(negedge clk); get_out(4, rdy, dn, res, co, ov, zr); g++; end
    set_in(4, 1'b1, 32'h1234, 32'h1111, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);   // start pulse in RUN
    @(posedge clk); #1;
    set_in(4, 1'b0, 32'hFFFF, 32'hFFFF, 1'b1);
    dn = 1'b0;
    for (int c = 0; c < 20 && !dn; c++) begin
      @(posedge clk); #1;
      get_out(4, rdy, dn, res, co, ov, zr);
    end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL busy done: got %b expected 1", dn); end
    set_in(4, 1'b1, 32'h0000, 32'h0000, 1'b0);   // start pulse in DONE
    @(posedge clk); #1;
    set_in(4, 1'b0, 32'h0000, 32'h0000, 1'b0);
    get_out(4, rdy, dn, res, co, ov, zr);
    n_checks++; if ({rdy, dn} !== 2'b10) begin n_fail++; $display("FAIL busy idle: got ready=%b done=%b expected ready=1 done=0", rdy, dn); end
    @(posedge clk); #1;
    get_out(4, rdy, dn, res, co, ov, zr);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL busy not_accepted: got ready=%b expected 1", rdy); end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({res, co, ov, zr, dn} !== {32'h2345, 4'b0000}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got res=%h c=%b o=%b z=%b done=%b expected res=2345 c=0 o=0 z=0 done=0", c, res, co, ov, zr, dn);
      end
      @(posedge clk); #1;
      get_out(4, rdy, dn, res, co, ov, zr);
    end
  endtask

  task automatic test_back_to_back;
    logic rdy, dn, co, ov, zr;
    logic [31:0] res, er;
    logic ec, eo, ez;
    int pulses[$];
    int g;
    model(16, 32'h0F0F, 32'hF0F1, 1'b0, er, ec, eo, ez);
    @(negedge clk);
    get_out(4, rdy, dn, res, co, ov, zr);
    g = 0;
    while (!rdy && g < 30) begin @(negedge clk); get_out(4, rdy, dn, res, co, ov, zr); g++; end
    set_in(4, 1'b1, 32'h0F0F, 32'hF0F1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      get_out(4, rdy, dn, res, co, ov, zr);
      if (dn) pulses.push_back(c);
    end
    set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++; if (pulses.size() !== 2) begin n_fail++; $display("FAIL b2b pulse_count: got %0d expected 2", pulses.size()); end
    if (pulses.size() == 2) begin
      n_checks++; if (pulses[0] !== 5) begin n_fail++; $display("FAIL b2b first_done: got cycle %0d expected 5", pulses[0]); end
      n_checks++; if (pulses[1] - pulses[0] !== 6) begin n_fail++; $display("FAIL b2b spacing: got %0d expected 6", pulses[1] - pulses[0]); end
    end
    n_checks++; if ({res, co, ov, zr} !== {er, ec, eo, ez}) begin n_fail++; $display("FAIL b2b result: got res=%h c=%b o=%b z=%b expected res=%h c=%b o=%b z=%b", res, co, ov, zr, er, ec, eo, ez); end
  endtask

  task automatic test_reset_mid;
    logic rdy, dn, co, ov, zr, seen;
    logic [31:0] res;
    int g, lat;
    @(negedge clk);
    get_out(4, rdy, dn, res, co, ov, zr);
    g = 0;
    while (!rdy && g < 30) begin @(negedge clk); get_out(4, rdy, dn, res, co, ov, zr); g++; end
    set_in(4, 1'b1, 32'hAAAA, 32'h1111, 1'b0);
    @(posedge clk); #1;                  // accept edge
    set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;                  // nibble 1 captured
    @(posedge clk); #1;                  // nibble 2 captured
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    get_out(4, rdy, dn, res, co, ov, zr);
    n_checks++; if ({rdy, dn} !== 2'b10) begin n_fail++; $display("FAIL midrst handshake: got ready=%b done=%b expected ready=1 done=0", rdy, dn); end
    n_checks++; if ({res, co, ov, zr} !== 35'h0) begin n_fail++; $display("FAIL midrst outputs: got res=%h c=%b o=%b z=%b expected all 0", res, co, ov, zr); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      get_out(4, rdy, dn, res, co, ov, zr);
      if (dn) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst no_done: got done pulse %b expected 0", seen); end
    run_op(4, 32'h1234, 32'h4321, 1'b0, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'h5555, 3'b000}) begin n_fail++; $display("FAIL midrst fresh_op: got res=%h c=%b o=%b z=%b expected res=5555 c=0 o=0 z=0", res, co, ov, zr); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL midrst latency: got %0d expected 5", lat); end
  endtask

  task automatic test_nibbles1;
    logic co, ov, zr, ec, eo, ez;
    logic [31:0] res, er, a, b;
    logic sub;
    int lat;
    run_op(1, 32'h7, 32'h1, 1'b0, res, co, ov, zr, lat);
    n_checks++; if ({res, co, ov, zr} !== {32'h8, 3'b010}) begin n_fail++; $display("FAIL n1 directed: got res=%h c=%b o=%b z=%b expected res=8 c=0 o=1 z=0", res, co, ov, zr); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL n1 latency: got %0d expected 2", lat); end
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 15));
      b = 32'($urandom_range(0, 15));
      sub = 1'($urandom_range(0, 1));
      model(4, a, b, sub, er, ec, eo, ez);
      run_op(1, a, b, sub, res, co, ov, zr, lat);
      n_checks++;
      if ({res, co, ov, zr} !== {er, ec, eo, ez} || lat !== 2) begin
        n_fail++;
        $display("FAIL n1 random a=%h b=%h sub=%b: got res=%h c=%b o=%b z=%b lat=%0d expected res=%h c=%b o=%b z=%b lat=2", a, b, sub, res, co, ov, zr, lat, er, ec, eo, ez);
      end
    end
  endtask

  task automatic test_random_n4;
    logic co, ov, zr, ec, eo, ez;
    logic [31:0] res, er, a, b;
    logic sub;
    int lat;
    for (int i = 0; i < 100; i++) begin
      a = 32'($urandom_range(0, 16'hFFFF));
      b = 32'($urandom_range(0, 16'hFFFF));
      sub = 1'($urandom_range(0, 1));
      model(16, a, b, sub, er, ec, eo, ez);
      run_op(4, a, b, sub, res, co, ov, zr, lat);
      n_checks++;
      if ({res, co, ov, zr} !== {er, ec, eo, ez} || lat !== 5) begin
        n_fail++;
        $display("FAIL n4 random a=%h b=%h sub=%b: got res=%h c=%b o=%b z=%b lat=%0d expected res=%h c=%b o=%b z=%b lat=5", a, b, sub, res, co, ov, zr, lat, er, ec, eo, ez);
      end
    end
  endtask

  task automatic test_random_n8;
    logic co, ov, zr, ec, eo, ez;
    logic [31:0] res, er, a, b;
    logic sub;
    int lat;
    logic [64:0] corners [4];
    corners[0] = {32'h7FFFFFFF, 32'h00000001, 1'b0};
    corners[1] = {32'h80000000, 32'h00000001, 1'b1};
    corners[2] = {32'hFFFFFFFF, 32'h00000001, 1'b0};
    corners[3] = {32'h12345678, 32'h12345678, 1'b1};
    for (int i = 0; i < 1000; i++) begin
      if (i < 4) begin
        {a, b, sub} = corners[i];
      end else begin
        a = $urandom();
        b = $urandom();
        sub = 1'($urandom_range(0, 1));
      end
      model(32, a, b, sub, er, ec, eo, ez);
      run_op(8, a, b, sub, res, co, ov, zr, lat);
      n_checks++;
      if ({res, co, ov, zr} !== {er, ec, eo, ez} || lat !== 9) begin
        n_fail++;
        $display("FAIL n8 random a=%h b=%h sub=%b: got res=%h c=%b o=%b z=%b lat=%0d expected res=%h c=%b o=%b z=%b lat=9", a, b, sub, res, co, ov, zr, lat, er, ec, eo, ez);
      end
    end
  endtask

  initial begin
    set_in(1, 1'b0, 32'h0, 32'h0, 1'b0);
    set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
    set_in(8, 1'b0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_directed();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    test_nibbles1();
    test_random_n4();
    test_random_n8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
